// File: rtl/reg_file_clr_if.sv
// reg_file_clr_if -- bus bundle for the clearable register file.
//   master : drives clr_req, we, wa, wd, ra1, ra2, dbg_a; samples rd1, rd2, dbg_d, busy
//   slave  : the register file itself
//   N = address width (2^N registers), W = data width
interface reg_file_clr_if #(
    parameter int N = 5,
    parameter int W = 32
);
    logic         clr_req;
    logic         we;
    logic [N-1:0] wa;
    logic [W-1:0] wd;
    logic [N-1:0] ra1;
    logic [N-1:0] ra2;
    logic [W-1:0] rd1;
    logic [W-1:0] rd2;
    logic [N-1:0] dbg_a;
    logic [W-1:0] dbg_d;
    logic         busy;

    modport master (
        output clr_req, we, wa, wd, ra1, ra2, dbg_a,
        input  rd1, rd2, dbg_d, busy
    );

    modport slave (
        input  clr_req, we, wa, wd, ra1, ra2, dbg_a,
        output rd1, rd2, dbg_d, busy
    );
endinterface

// File: rtl/reg_file_clr.sv
// reg_file_clr -- 2^N x W register file with a hardware clear sweep.
//   clk : single clock, all state updates on the rising edge
//   rst : synchronous active-high reset; starts a clear sweep from index 0
//   bus : reg_file_clr_if.slave
//         clr_req     - start a clear sweep (honoured only when not sweeping)
//         we/wa/wd    - write port; address 0 is hardwired to zero
//         ra1/ra2     - combinational read addresses, rd1/rd2 read data
//         dbg_a/dbg_d - combinational debug read port
//         busy        - a clear sweep is in progress; all reads return 0
// Reads are write-first: a write in flight is forwarded to any matching
// read port in the same cycle.
module reg_file_clr #(
    parameter int N = 5,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    reg_file_clr_if.slave  bus
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] idx;
    logic [N-1:0] idx_nxt;

    logic [W-1:0] mem [2**N];

    logic         mem_we;
    logic [N-1:0] mem_wa;
    logic [W-1:0] mem_wd;
    logic         fwd;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        unique case (state)
            CLEAR: begin
                // clr_req is deliberately not looked at here: a sweep never restarts.
                idx_nxt = idx + N'(1);
                if (&idx) state_nxt = RUN;
            end
            RUN: begin
                if (bus.clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                idx_nxt   = '0;
            end
        endcase
    end

    // Single shared write port: the sweep owns it in CLEAR, the user in RUN.
    // A write coinciding with clr_req still lands; the sweep erases it later.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = bus.wa;
        mem_wd = bus.wd;
        if (!rst) begin
            if (state == CLEAR) begin
                mem_we = 1'b1;
                mem_wa = idx;
                mem_wd = '0;
            end else if (bus.we && (bus.wa != '0)) begin
                mem_we = 1'b1;
            end
        end
    end

    // NOTE: the array has no reset; its contents are defined by the clear
    // sweep instead, which keeps it mappable to distributed RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    assign bus.busy = (state == CLEAR);
    assign fwd      = (state == RUN) && bus.we && (bus.wa != '0);

    function automatic logic [W-1:0] read_port(input logic [N-1:0] a);
        if (state == CLEAR || a == '0) return '0;
        if (fwd && a == bus.wa)        return bus.wd;
        return mem[a];
    endfunction

    assign bus.rd1   = read_port(bus.ra1);
    assign bus.rd2   = read_port(bus.ra2);
    assign bus.dbg_d = read_port(bus.dbg_a);

endmodule

// File: tb/tb_reg_file_clr.sv
// tb_reg_file_clr -- scoreboard bench for reg_file_clr.
// The driver computes the expected read results from a behavioural model
// (an array plus a "cycles of sweep left" counter) and queues them; a
// monitor on the falling edge pops and compares against the DUT outputs.
module tb_reg_file_clr;
    localparam int N    = 5;
    localparam int W    = 32;
    localparam int SIZE = 2**N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_clr_if #(.N(N), .W(W)) bus ();

    reg_file_clr #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] rd1;
        logic [W-1:0] rd2;
        logic [W-1:0] dbg;
        logic         busy;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: register contents and remaining sweep cycles.
    logic [W-1:0] model_mem [SIZE];
    int           sweep_left;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [W-1:0] model_read(input logic [N-1:0] a);
        if (sweep_left > 0 || a == 0) return '0;
        if (bus.we && bus.wa != 0 && a == bus.wa) return bus.wd;
        return model_mem[a];
    endfunction

    // Drive one cycle: inputs are already applied, queue expectations,
    // cross the rising edge and advance the model.
    task automatic cycle(input logic r, input logic clr, input logic w,
                         input logic [N-1:0] a, input logic [W-1:0] d,
                         input logic [N-1:0] r1, input logic [N-1:0] r2,
                         input logic [N-1:0] dbg);
        exp_t e;
        rst         = r;
        bus.clr_req = clr;
        bus.we      = w;
        bus.wa      = a;
        bus.wd      = d;
        bus.ra1     = r1;
        bus.ra2     = r2;
        bus.dbg_a   = dbg;
        e.rd1  = model_read(r1);
        e.rd2  = model_read(r2);
        e.dbg  = model_read(dbg);
        e.busy = (sweep_left > 0);
        exp_q.push_back(e);
        @(posedge clk);
        if (r) begin
            sweep_left = SIZE;
            foreach (model_mem[i]) model_mem[i] = '0;
        end else if (sweep_left > 0) begin
            sweep_left--;
        end else begin
            if (w && a != 0) model_mem[a] = d;
            if (clr) begin
                sweep_left = SIZE;
                foreach (model_mem[i]) model_mem[i] = '0;
            end
        end
        #1;
    endtask

    task automatic idle(input logic [N-1:0] r1);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, r1, r1 ^ 5'h1f, r1 ^ 5'h0a);
    endtask

    // Monitor: compares whatever the driver queued for this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rd1",   bus.rd1,   e.rd1);
            check("rd2",   bus.rd2,   e.rd2);
            check("dbg_d", bus.dbg_d, e.dbg);
            check("busy",  {{(W-1){1'b0}}, bus.busy}, {{(W-1){1'b0}}, e.busy});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] r1;
        sweep_left = SIZE;
        foreach (model_mem[i]) model_mem[i] = '0;
        bus.clr_req = 1'b0;
        bus.we      = 1'b0;
        bus.wa      = '0;
        bus.wd      = '0;
        bus.ra1     = '0;
        bus.ra2     = '0;
        bus.dbg_a   = '0;
        // First edge establishes a known state; nothing is checked before it.
        @(posedge clk);
        #1;

        // One reset cycle, then idle: busy for exactly SIZE edges, all zero.
        cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0);
        for (int i = 0; i < SIZE + 2; i++) idle(5'(i));
        for (int i = 0; i < SIZE; i++) idle(5'(i));

        // Bypass then array read of register 5.
        cycle(1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 5'd5, 5'd5, 5'd3);

        // Writes to register 0 are discarded.
        cycle(1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 5'd0, 5'd5, 5'd0);

        // Register 7 on the debug port while the other ports read elsewhere.
        cycle(1'b0, 1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd5, 5'd2, 5'd7);
        cycle(1'b0, 1'b0, 1'b1, 5'd2, 32'h00C0FFEE, 5'd5, 5'd2, 5'd7);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 5'd5, 5'd2, 5'd7);

        // Write reg 31 together with clr_req; writes and clr_req during sweep dropped.
        cycle(1'b0, 1'b0, 1'b1, 5'd31, 32'h12345678, 5'd31, 5'd31, 5'd31);
        cycle(1'b0, 1'b1, 1'b1, 5'd9, 32'h99999999, 5'd31, 5'd9, 5'd7);
        for (int i = 0; i < SIZE + 2; i++)
            cycle(1'b0, (i == 4), 1'b1, 5'(i), 32'h5000_0000 + i, 5'(i), 5'd31, 5'd7);
        for (int i = 0; i < 4; i++) idle(5'(31 - i));

        // Reset in the middle of a sweep restarts it from index 0.
        cycle(1'b0, 1'b1, 1'b0, '0, '0, 5'd1, 5'd2, 5'd3);
        for (int i = 0; i < 10; i++) idle(5'(i));
        cycle(1'b1, 1'b0, 1'b1, 5'd4, 32'h44444444, 5'd4, 5'd4, 5'd4);
        for (int i = 0; i < SIZE + 2; i++) idle(5'(i));

        // Randomized traffic: reads biased towards the write address to hit the bypass.
        for (int i = 0; i < 600; i++) begin
            a  = 5'($urandom_range(0, SIZE - 1));
            r1 = ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, SIZE - 1));
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 1) == 1),
                  a, $urandom(), r1,
                  ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, SIZE - 1)),
                  5'($urandom_range(0, SIZE - 1)));
        end
        for (int i = 0; i < SIZE + 2; i++) idle(5'(i));

        @(negedge clk);
        #1;
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/reg_file_clr.md
REG_FILE_CLR -- requirements
Module: reg_file_clr

Interface
REQ-001 The block SHALL have parameter N, default 5, meaning register address width; the file holds 2^N registers.
REQ-002 The block SHALL have parameter W, default 32, meaning register data width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-005 The block SHALL have port clr_req, input, 1, meaning request a full clear sweep.
REQ-006 The block SHALL have port we, input, 1, meaning write enable.
REQ-007 The block SHALL have port wa, input, N, meaning write address, driven by the destination-select mux output.
REQ-008 The block SHALL have port wd, input, W, meaning write data.
REQ-009 The block SHALL have ports ra1 and ra2, input, N each, meaning read addresses.
REQ-010 The block SHALL have ports rd1 and rd2, output, W each, meaning read data.
REQ-011 The block SHALL have port dbg_a, input, N, meaning debug read address.
REQ-012 The block SHALL have port dbg_d, output, W, meaning debug read data.
REQ-013 The block SHALL have port busy, output, 1, meaning a clear sweep is in progress.

Function
REQ-014 The storage SHALL be an array of 2^N words of W bits, written at most one word per cycle so that it maps to distributed RAM.
REQ-015 The FSM SHALL have exactly two states: CLEAR and RUN, plus an N-bit sweep index idx.
REQ-016 In CLEAR, each cycle SHALL write 0 to mem[idx] and increment idx; when idx = 2^N-1 is cleared, the next state SHALL be RUN.
REQ-017 A full sweep SHALL take exactly 2^N cycles (32 at default).
REQ-018 In RUN, clr_req=1 SHALL move the FSM to CLEAR with idx=0 on the next edge.
REQ-019 clr_req SHALL be ignored while in CLEAR; the sweep does not restart.
REQ-020 busy SHALL be 1 in CLEAR and 0 in RUN, decoded from the registered state only.
REQ-021 In RUN, we=1 with wa≠0 SHALL write wd to mem[wa] on the edge.
REQ-022 A write to address 0 SHALL be discarded; register 0 always reads 0.
REQ-023 In CLEAR, all writes SHALL be dropped, never queued.
REQ-024 When clr_req and a write coincide in RUN, the write SHALL be performed; the sweep then erases it.
REQ-025 Reads SHALL be combinational, zero-cycle latency: rdX = mem[raX], dbg_d = mem[dbg_a].
REQ-026 Address 0 on any read port SHALL return 0 regardless of array contents.
REQ-027 Write-first bypass rule: in RUN, if we=1, wa≠0 and raX=wa, rdX SHALL equal wd in the same cycle; the same applies to dbg_d.
REQ-028 While busy=1, rd1, rd2 and dbg_d SHALL all be 0.

Reset
REQ-029 rst=1 on an edge SHALL force state CLEAR and idx=0, whatever the current state or idx.
REQ-030 Reset SHALL also restart a sweep already in progress from idx 0.
REQ-031 busy SHALL be 1 from the first edge with rst=1, and SHALL remain 1 for 2^N edges after rst deasserts.
REQ-032 All read outputs SHALL be 0 while busy=1; array contents are defined only after the first sweep completes.

Verification
REQ-033 Scenario: rst 1 cycle, then idle -> busy=1 for exactly 32 edges, then 0; rd1 for ra1=0..31 all read 0.
REQ-034 Scenario: in RUN, we=1, wa=5, wd=0xDEADBEEF; ra1=5 in the same cycle -> rd1=0xDEADBEEF via bypass; next cycle with we=0 -> rd1=0xDEADBEEF from the array.
REQ-035 Scenario: we=1, wa=0, wd=0xFFFFFFFF -> rd1 for ra1=0 is 0 in the write cycle and in later cycles.
REQ-036 Scenario: write 0x12345678 to reg 31, pulse clr_req -> busy=1 next cycle for 32 cycles; writes during this window dropped; reg 31 reads 0 afterwards.
REQ-037 Scenario: rst asserted at sweep cycle 10 -> idx restarts at 0; busy stays 1 for 32 more edges after rst deasserts.
REQ-038 Scenario: dbg_a=7 after writing 0xA5A5A5A5 to reg 7 -> dbg_d=0xA5A5A5A5 while ra1 and ra2 independently read other registers.
